// File: rtl/image_downsample_machine_if.sv
// Host-side bus of the image down-sampler: command, load/read address, pixel in,
// result pixel out and the processing-complete flag.
interface image_downsample_machine_if #(
    parameter int AW     = 16,
    parameter int DATA_W = 8
);
    logic [1:0]        status;
    logic [DATA_W-1:0] data;
    logic [AW-1:0]     addr;
    logic              end_process;
    logic [DATA_W-1:0] out;

    modport master (output status, data, addr, input end_process, out);
    modport slave  (input status, data, addr, output end_process, out);
endinterface

// File: rtl/image_downsample_machine.sv
// 3x3 Gaussian low-pass plus 2:1 decimation of a square grayscale image held in
// on-chip memory; one neighbour read per clock, result written to a quarter-size memory.
module image_downsample_machine #(
    parameter int IMG_W  = 256,
    parameter int DATA_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    image_downsample_machine_if.slave   bus
);
    localparam int PW    = $clog2(IMG_W);
    localparam int QW    = PW - 1;
    localparam int AW    = 2 * PW;
    localparam int OAW   = 2 * QW;
    localparam int ACC_W = DATA_W + 4;

    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_PROC = 2'b01;
    localparam logic [1:0] CMD_LOAD = 2'b10;
    localparam logic [1:0] CMD_READ = 2'b11;

    typedef enum logic [2:0] {IDLE, LOAD, PROC, DONE, READ} state_t;

    logic [DATA_W-1:0] in_mem  [2**AW];
    logic [DATA_W-1:0] out_mem [2**OAW];

    state_t            state_q, state_d;
    logic [QW-1:0]     orow_q, orow_d, ocol_q, ocol_d;
    logic [3:0]        tap_q, tap_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [1:0]        shift_q, shift_d;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] in_rd_q;

    logic [1:0]        row_sel, col_sel, tap_shift;
    logic [PW-1:0]     rd_row, rd_col;
    logic [ACC_W-1:0]  acc_sum, acc_rnd;
    logic              proc_run, px_wr, last_px;

    // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        orow_d    = orow_q;
        ocol_d    = ocol_q;
        tap_d     = tap_q;
        acc_d     = acc_q;
        row_sel   = 2'd2;
        col_sel   = 2'd2;
        tap_shift = 2'd0;
        px_wr     = 1'b0;

        // Tap order is raster over the 3x3 window; shift encodes weights 1/2/4.
        case (tap_q)
            4'd0:    begin row_sel = 2'd0; col_sel = 2'd0; tap_shift = 2'd0; end
            4'd1:    begin row_sel = 2'd0; col_sel = 2'd1; tap_shift = 2'd1; end
            4'd2:    begin row_sel = 2'd0; col_sel = 2'd2; tap_shift = 2'd0; end
            4'd3:    begin row_sel = 2'd1; col_sel = 2'd0; tap_shift = 2'd1; end
            4'd4:    begin row_sel = 2'd1; col_sel = 2'd1; tap_shift = 2'd2; end
            4'd5:    begin row_sel = 2'd1; col_sel = 2'd2; tap_shift = 2'd1; end
            4'd6:    begin row_sel = 2'd2; col_sel = 2'd0; tap_shift = 2'd0; end
            4'd7:    begin row_sel = 2'd2; col_sel = 2'd1; tap_shift = 2'd1; end
            default: begin row_sel = 2'd2; col_sel = 2'd2; tap_shift = 2'd0; end
        endcase

        // Centres are even, so only the -1 neighbour of row/col 0 can leave the image.
        case (row_sel)
            2'd0:    rd_row = (orow_q == '0) ? '0 : {orow_q, 1'b0} - PW'(1);
            2'd1:    rd_row = {orow_q, 1'b0};
            default: rd_row = {orow_q, 1'b1};
        endcase
        case (col_sel)
            2'd0:    rd_col = (ocol_q == '0) ? '0 : {ocol_q, 1'b0} - PW'(1);
            2'd1:    rd_col = {ocol_q, 1'b0};
            default: rd_col = {ocol_q, 1'b1};
        endcase

        acc_sum  = acc_q + (ACC_W'(in_rd_q) << shift_q);
        acc_rnd  = acc_sum + ACC_W'(8);
        shift_d  = tap_shift;
        proc_run = (state_q == PROC) && (bus.status == CMD_PROC);
        last_px  = (orow_q == '1) && (ocol_q == '1);

        if (state_q != PROC) begin
            orow_d = '0;
            ocol_d = '0;
            tap_d  = '0;
            acc_d  = '0;
        end else if (proc_run) begin
            if (tap_q == 4'd9) begin
                px_wr  = 1'b1;
                tap_d  = '0;
                acc_d  = '0;
                ocol_d = ocol_q + 1'b1;
                if (ocol_q == '1) orow_d = orow_q + 1'b1;
            end else begin
                tap_d = tap_q + 4'd1;
                acc_d = (tap_q == 4'd0) ? '0 : acc_sum;
            end
        end

        case (bus.status)
            CMD_LOAD: state_d = LOAD;
            CMD_READ: state_d = READ;
            CMD_IDLE: state_d = IDLE;
            default: begin
                if (state_q == DONE || (px_wr && last_px)) state_d = DONE;
                else                                       state_d = PROC;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            orow_q  <= '0;
            ocol_q  <= '0;
            tap_q   <= '0;
            acc_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
            tap_q   <= tap_d;
            acc_q   <= acc_d;
            shift_q <= shift_d;
            if (bus.status == CMD_READ) out_q <= out_mem[bus.addr[OAW-1:0]];
        end
    end

    // NOTE: memories and their read register are deliberately left out of reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (bus.status == CMD_LOAD) in_mem[bus.addr] <= bus.data;
        in_rd_q <= in_mem[{rd_row, rd_col}];
        if (px_wr) out_mem[{orow_q, ocol_q}] <= acc_rnd[ACC_W-1:4];
    end

    assign bus.end_process = (state_q == DONE);
    assign bus.out         = out_q;
endmodule

// File: tb/tb_image_downsample_machine.sv
// Scoreboarded bench for image_downsample_machine on a 16x16 image: directed images,
// hand-derived expected results, handshake timing and mid-process reset.
module tb_image_downsample_machine;
    localparam int IMG_W = 16;
    localparam int OW    = IMG_W / 2;
    localparam int NPIX  = IMG_W * IMG_W;
    localparam int NOUT  = OW * OW;
    localparam int AW    = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    image_downsample_machine_if #(.AW(AW), .DATA_W(8)) bus ();

    image_downsample_machine #(.IMG_W(IMG_W), .DATA_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         idx;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic rd_issue   = 1'b0;
    logic rd_issue_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // kinds: 0 uniform 100, 1 impulse at (2,2), 2 corner 255, 3 horizontal ramp
    function automatic logic [7:0] pix(input int kind, input int a);
        int r = a / IMG_W;
        int c = a % IMG_W;
        case (kind)
            0:       return 8'd100;
            1:       return (r == 2 && c == 2) ? 8'd160 : 8'd0;
            2:       return (a == 0) ? 8'd255 : 8'd0;
            default: return 8'(c);
        endcase
    endfunction

    function automatic logic [7:0] expv(input int kind, input int k);
        case (kind)
            0:       return 8'd100;
            1:       return (k == OW + 1) ? 8'd40 : 8'd0;
            2:       return (k == 0) ? 8'd143 : 8'd0;
            default: return 8'(2 * (k % OW));
        endcase
    endfunction

    always @(posedge clk) rd_issue_d <= rd_issue;

    always @(negedge clk) begin
        if (rd_issue_d) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_read: got %0d, expected no pending read", bus.out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("out[%0d]", e.idx), bus.out, e.val);
            end
        end
    end

    task automatic load_image(input int kind);
        int bad = 0;
        for (int a = 0; a < NPIX; a++) begin
            bus.status = 2'b10;
            bus.addr   = AW'(a);
            bus.data   = pix(kind, a);
            @(negedge clk);
            if (bus.end_process !== 1'b0) bad++;
        end
        bus.status = 2'b00;
        @(negedge clk);
        check("ep_low_during_load", bad, 0);
    endtask

    task automatic run_process(input string tag);
        int cyc  = 1;
        int hold = 0;
        bus.status = 2'b01;
        @(negedge clk);
        check({tag, "_ep_low_at_start"}, bus.end_process, 0);
        while (bus.end_process !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_ep_rise"}, bus.end_process, 1);
        check({tag, "_proc_clocks_in_range"}, (cyc >= 9 * NOUT) && (cyc <= 12 * NOUT), 1);
        repeat (3) begin
            @(negedge clk);
            if (bus.end_process !== 1'b1) hold++;
        end
        check({tag, "_ep_holds"}, hold, 0);
    endtask

    task automatic read_all(input int kind);
        exp_t e;
        for (int k = 0; k < NOUT; k++) begin
            bus.status = 2'b11;
            bus.addr   = AW'(k + ((k & 3) << 6));
            rd_issue   = 1'b1;
            e.idx      = k;
            e.val      = expv(kind, k);
            exp_q.push_back(e);
            @(negedge clk);
            if (k == 0) check("ep_fall_after_read", bus.end_process, 0);
        end
        rd_issue   = 1'b0;
        bus.status = 2'b00;
        bus.addr   = '0;
        @(negedge clk);
        @(negedge clk);
        check("out_holds_in_idle", bus.out, expv(kind, NOUT - 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.status = 2'b00;
        bus.addr   = '0;
        bus.data   = '0;
        #12;
        check("reset_end_process", bus.end_process, 0);
        check("reset_out", bus.out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int kind = 0; kind < 4; kind++) begin
            load_image(kind);
            run_process($sformatf("img%0d", kind));
            read_all(kind);
        end

        load_image(0);
        bus.status = 2'b01;
        repeat (NOUT * 5) @(negedge clk);
        check("ep_low_mid_proc", bus.end_process, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_end_process", bus.end_process, 0);
        check("midreset_out", bus.out, 0);
        bus.status = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_process("rerun");
        read_all(0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
